// File: rtl/activation_pack.sv
// Activation + int8 packing stage.
// Applies identity / ReLU / leaky-ReLU to each normalized 32-bit sample,
// saturates it to int8, packs four lanes per 32-bit word and buffers
// completed (or flushed partial) words in a first-word-fall-through FIFO.
//
// Ports:
//   clk        clock, all state on rising edge
//   reset      asynchronous active-high reset
//   valid_in   data_in valid this cycle (upstream cannot stall)
//   data_in    signed 32-bit normalized sample
//   act_mode   0 identity, 1 ReLU, 2 leaky ReLU, 3 identity
//   flush      emit the partially filled word (if any)
//   out_valid  FIFO non-empty; out_data/out_bytes hold the head word
//   out_ready  consumer accepts the head word
//   out_data   packed lanes, lane 0 in [7:0]
//   out_bytes  valid lanes in out_data, 1..4
//   overflow   sticky: a word was dropped because the FIFO was full
module activation_pack #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  logic signed [31:0] data_in,
  input  logic [1:0]         act_mode,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic [2:0]         out_bytes,
  output logic               overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(FIFO_DEPTH);

  // Activation and saturation
  logic signed [31:0] act_val;
  logic [7:0]         lane_byte;

  always_comb begin
    act_val = data_in;
    unique case (act_mode)
      2'd1:    act_val = data_in[31] ? 32'sd0 : data_in;
      2'd2:    act_val = data_in[31] ? (data_in >>> 3) : data_in;
      default: act_val = data_in;
    endcase
    if (act_val > 32'sd127) begin
      lane_byte = 8'h7f;
    end else if (act_val < -32'sd128) begin
      lane_byte = 8'h80;
    end else begin
      lane_byte = act_val[7:0];
    end
  end

  // Lane packing
  logic [1:0]  lane_ptr_q, lane_ptr_d;
  logic [31:0] pack_q, pack_d;
  logic [31:0] word_new;
  logic        push;
  logic [2:0]  push_bytes;

  always_comb begin
    word_new   = pack_q;
    lane_ptr_d = lane_ptr_q;
    pack_d     = pack_q;
    push       = 1'b0;
    push_bytes = 3'd0;
    if (valid_in) begin
      word_new[{lane_ptr_q, 3'b000} +: 8] = lane_byte;
      if (lane_ptr_q == 2'd3 || flush) begin
        // New byte is included before the word leaves
        push       = 1'b1;
        push_bytes = {1'b0, lane_ptr_q} + 3'd1;
        lane_ptr_d = 2'd0;
        pack_d     = '0;
      end else begin
        lane_ptr_d = lane_ptr_q + 2'd1;
        pack_d     = word_new;
      end
    end else if (flush && lane_ptr_q != 2'd0) begin
      push       = 1'b1;
      push_bytes = {1'b0, lane_ptr_q};
      lane_ptr_d = 2'd0;
      pack_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_ptr_q <= 2'd0;
      pack_q     <= '0;
    end else begin
      lane_ptr_q <= lane_ptr_d;
      pack_q     <= pack_d;
    end
  end

  // FWFT FIFO
  logic [34:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, pop, wr_en;
  logic          overflow_q;

  assign full  = (count_q == DepthC);
  assign pop   = out_valid & out_ready;
  // A pop frees the head slot at the same edge, so a full FIFO still accepts
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {push_bytes, word_new};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (wr_en && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (!wr_en && pop) begin
        count_q <= count_q - CW'(1);
      end
      if (push && !wr_en) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Outputs gated by occupancy so reset forces them to zero immediately
  always_comb begin
    out_valid = (count_q != '0);
    out_data  = out_valid ? mem_q[rd_ptr_q][31:0]  : 32'd0;
    out_bytes = out_valid ? mem_q[rd_ptr_q][34:32] : 3'd0;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_activation_pack.sv
module tb_activation_pack;

  localparam int Depth = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               valid_in = 1'b0;
  logic signed [31:0] data_in = '0;
  logic [1:0]         act_mode = '0;
  logic               flush = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [31:0]        out_data;
  logic [2:0]         out_bytes;
  logic               overflow;

  int n_checks = 0;
  int n_fail   = 0;

  activation_pack #(.FIFO_DEPTH(Depth)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .act_mode  (act_mode),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_bytes (out_bytes),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte value from the arithmetic definition
  function automatic logic [7:0] act_sat(input int x, input logic [1:0] m);
    longint y;
    y = x;
    if (m == 2'd1 && x < 0) y = 0;
    if (m == 2'd2 && x < 0) y = -((-longint'(x) + 7) / 8);  // floor(x/8)
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    return y[7:0];
  endfunction

  logic [7:0]  m_lanes[$];
  logic [34:0] m_fifo[$];
  logic        m_ovf = 1'b0;
  logic [34:0] dut_log[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lanes.delete();
      m_fifo.delete();
      m_ovf = 1'b0;
    end else begin
      logic        do_push;
      logic [31:0] w;
      logic [2:0]  nb;
      do_push = 1'b0;
      w = '0;
      nb = '0;
      if (valid_in) m_lanes.push_back(act_sat(data_in, act_mode));
      if (m_lanes.size() == 4 || (flush && m_lanes.size() > 0)) begin
        do_push = 1'b1;
        nb = 3'(m_lanes.size());
        for (int i = 0; i < m_lanes.size(); i++) w[8*i +: 8] = m_lanes[i];
        m_lanes.delete();
      end
      if (m_fifo.size() > 0 && out_ready) void'(m_fifo.pop_front());
      if (do_push) begin
        if (m_fifo.size() < Depth) m_fifo.push_back({nb, w});
        else m_ovf = 1'b1;
      end
    end
  end

  // Per-cycle compare against the model, plus a log of accepted words
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_bytes", out_bytes, 0);
      chk("rst_ovf", overflow, 0);
    end else begin
      chk("cmp_valid", out_valid, m_fifo.size() != 0);
      if (m_fifo.size() != 0) begin
        chk("cmp_data", out_data, m_fifo[0][31:0]);
        chk("cmp_bytes", out_bytes, m_fifo[0][34:32]);
      end
      chk("cmp_ovf", overflow, m_ovf);
      if (out_valid && out_ready) dut_log.push_back({out_bytes, out_data});
    end
  end

  function automatic logic [34:0] log_at(input int i);
    if (i < dut_log.size()) return dut_log[i];
    return '1;
  endfunction

  task automatic cyc(input logic v, input int d, input logic [1:0] m, input logic f);
    valid_in = v;
    data_in  = d;
    act_mode = m;
    flush    = f;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 2'd0, 1'b0);
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b1;
    #1;
    chk({nm, "_async_valid"}, out_valid, 0);
    chk({nm, "_async_data"}, out_data, 0);
    chk({nm, "_async_bytes"}, out_bytes, 0);
    chk({nm, "_async_ovf"}, overflow, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic int rand_data();
    int edges[8] = '{127, 128, -128, -129, -1024, -1025, -8, -9};
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 400)) - 200;
      1:       return int'($urandom);
      2:       return int'($urandom_range(0, 4000)) - 2000;
      default: return edges[$urandom_range(0, 7)];
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_valid", out_valid, 0);
    chk("reset_ovf", overflow, 0);

    // Pack and saturate
    dut_log.delete();
    cyc(1, 5, 0, 0);
    cyc(1, -3, 0, 0);
    cyc(1, 300, 0, 0);
    chk("t1_pre_valid", out_valid, 0);
    cyc(1, -1000, 0, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 32'h807FFD05);
    chk("t1_bytes", out_bytes, 4);
    idle(2);
    chk("t1_log_n", dut_log.size(), 1);

    // Activations
    dut_log.delete();
    cyc(1, -7, 1, 0);
    cyc(1, 9, 1, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 127, 1, 0);
    cyc(1, -16, 2, 0);
    cyc(1, -1, 2, 0);
    cyc(1, -2000, 2, 0);
    cyc(1, 40, 2, 0);
    idle(3);
    chk("t2_log_n", dut_log.size(), 2);
    chk("t2_w0", log_at(0), {3'd4, 32'h7F000900});
    chk("t2_w1", log_at(1), {3'd4, 32'h2880FFFE});

    // Flush
    dut_log.delete();
    cyc(1, 1, 0, 0);
    cyc(1, 2, 0, 0);
    cyc(1, 3, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 6, 0, 0);
    cyc(1, 7, 0, 1);
    idle(3);
    chk("t3_log_n", dut_log.size(), 2);
    chk("t3_w0", log_at(0), {3'd3, 32'h00030201});
    chk("t3_w1", log_at(1), {3'd2, 32'h00000706});
    dut_log.delete();
    cyc(0, 0, 0, 1);
    chk("t3_idle_valid", out_valid, 0);
    idle(2);
    chk("t3_idle_log", dut_log.size(), 0);

    // Backpressure and overflow
    dut_log.delete();
    out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) cyc(1, i, 0, 0);
    chk("t4_ovf_pre", overflow, 0);
    for (int i = 17; i <= 20; i++) cyc(1, i, 0, 0);
    chk("t4_ovf", overflow, 1);
    chk("t4_head", out_data, 32'h04030201);
    out_ready = 1'b1;
    idle(6);
    chk("t4_log_n", dut_log.size(), 4);
    chk("t4_w0", log_at(0), {3'd4, 32'h04030201});
    chk("t4_w1", log_at(1), {3'd4, 32'h08070605});
    chk("t4_w2", log_at(2), {3'd4, 32'h0C0B0A09});
    chk("t4_w3", log_at(3), {3'd4, 32'h100F0E0D});
    chk("t4_ovf_sticky", overflow, 1);
    do_reset("t4");

    // Full FIFO with simultaneous push and pop
    dut_log.delete();
    out_ready = 1'b0;
    for (int i = 1; i <= 19; i++) cyc(1, i, 0, 0);
    out_ready = 1'b1;
    cyc(1, 20, 0, 0);
    chk("t5_ovf", overflow, 0);
    idle(6);
    chk("t5_log_n", dut_log.size(), 5);
    chk("t5_w0", log_at(0), {3'd4, 32'h04030201});
    chk("t5_w4", log_at(4), {3'd4, 32'h14131211});

    // Reset mid-operation
    dut_log.delete();
    out_ready = 1'b0;
    for (int i = 1; i <= 14; i++) cyc(1, i, 0, 0);
    chk("t6_pre_valid", out_valid, 1);
    do_reset("t6");
    out_ready = 1'b1;
    idle(2);
    chk("t6_no_word", out_valid, 0);
    cyc(1, 32'h11, 0, 0);
    cyc(1, 32'h22, 0, 0);
    cyc(1, 32'h33, 0, 0);
    cyc(1, 32'h44, 0, 0);
    idle(3);
    chk("t6_log_n", dut_log.size(), 1);
    chk("t6_w0", log_at(0), {3'd4, 32'h44332211});

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 9) < 6);
      cyc($urandom_range(0, 1) == 1, rand_data(), 2'($urandom_range(0, 3)),
          $urandom_range(0, 9) == 0);
      if (i == 1500) do_reset("rnd");
    end
    out_ready = 1'b1;
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
